// File: rtl/flit_requester.sv
// flit_requester: buffers incoming flits and requests the switch arbiter one packet at a time.
// Define FLIT_REQUESTER_PKTCNT_EN to add the 16-bit pkt_count output (tails sent).
module flit_requester #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  input  logic [2:0]        in_flit_id,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit
`ifdef FLIT_REQUESTER_PKTCNT_EN
  ,output logic [15:0]      pkt_count
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]  ID_HDR  = 3'b001;
  localparam logic [2:0]  ID_TAIL = 3'b100;

  typedef struct packed {
    logic [2:0]        id;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      length_q, length_d;
  logic             hdr_sent_q, hdr_sent_d;
  logic             push, pop, empty, full;
  entry_t           head;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign length   = length_q;

  // hdr_sent_q marks that the current packet's header already left, so a
  // second header at the head means the previous packet lost its tail.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    hdr_sent_d = hdr_sent_q;
    pop        = 1'b0;
    req        = 1'b0;
    out_valid  = 1'b0;
    flit_id    = 3'b000;
    out_flit   = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head.id == ID_HDR) begin
            state_d  = S_REQ;
            length_d = head.data[11:0];
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (grant) state_d = S_SEND;
      end
      S_SEND: begin
        req = 1'b1;
        if (!empty) out_flit = head.data;
        if (!empty && head.id == ID_HDR && hdr_sent_q) begin
          state_d    = S_REQ;
          length_d   = head.data[11:0];
          hdr_sent_d = 1'b0;
        end else if (!grant) begin
          state_d = S_REQ;
        end else if (!empty) begin
          out_valid = 1'b1;
          pop       = 1'b1;
          flit_id   = head.id;
          if (head.id == ID_HDR) hdr_sent_d = 1'b1;
          if (head.id == ID_TAIL) begin
            state_d    = S_IDLE;
            hdr_sent_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      length_q   <= '0;
      hdr_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      hdr_sent_q <= hdr_sent_d;
      cnt_q      <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; out_flit is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'({in_flit_id, in_flit});
  end

`ifdef FLIT_REQUESTER_PKTCNT_EN
  logic        tail_pop;
  logic [15:0] pkt_count_q;

  assign tail_pop  = pop && (state_q == S_SEND) && (head.id == ID_TAIL);
  assign pkt_count = pkt_count_q;

  always_ff @(posedge clk) begin
    if (rst)           pkt_count_q <= '0;
    else if (tail_pop) pkt_count_q <= pkt_count_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_flit_requester.sv
// tb_flit_requester: directed stimulus with a scoreboard of expected output flits.
module tb_flit_requester;

  localparam int unsigned DATA_W = 32;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_flit;
  logic [2:0]        in_flit_id;
  logic              grant, req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              out_valid;
  logic [DATA_W-1:0] out_flit;
`ifdef FLIT_REQUESTER_PKTCNT_EN
  logic [15:0]       pkt_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W+2:0] sb[$];

  flit_requester #(.DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit), .in_flit_id(in_flit_id),
    .grant(grant), .req(req), .flit_id(flit_id), .length(length),
    .out_valid(out_valid), .out_flit(out_flit)
`ifdef FLIT_REQUESTER_PKTCNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit and hold it until accepted; exp queues it as an expected output.
  task automatic push(input logic [2:0] id, input logic [DATA_W-1:0] data, input bit exp);
    bit ok;
    in_valid   = 1'b1;
    in_flit_id = id;
    in_flit    = data;
    if (exp) sb.push_back({id, data});
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      step();
      if (ok) break;
      if (i == 49) begin
        errors++;
        $display("FAIL push_timeout: in_ready stuck at 0 expected 1");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (req && n < 100) begin
      step();
      n++;
    end
    chk({name, "_req_drop"}, 32'(req), 32'd0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every transferred flit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit: got id %0h data %0h expected none", flit_id, out_flit);
        end else begin
          logic [DATA_W+2:0] e;
          e = sb.pop_front();
          if ({flit_id, out_flit} !== e) begin
            errors++;
            $display("FAIL flit_out: got id %0h data %0h expected id %0h data %0h",
                     flit_id, out_flit, e[DATA_W+2:DATA_W], e[DATA_W-1:0]);
          end
        end
      end else if (flit_id !== 3'b000) begin
        checks++;
        errors++;
        $display("FAIL idle_flit_id: got %0h expected 0", flit_id);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_flit_id = 3'b000; grant = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_req",       32'(req),       32'd0);
    chk("rst_flit_id",   32'(flit_id),   32'd0);
    chk("rst_length",    32'(length),    32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flit",  32'(out_flit),  32'd0);
`ifdef FLIT_REQUESTER_PKTCNT_EN
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
`endif

    // Basic packet with grant held high
    grant = 1'b1;
    push(HDR, 32'hABCD_0005, 1'b1);
    chk("t1_req_after_1_edge", 32'(req), 32'd0);
    push(BODY, 32'h1111_1111, 1'b1);
    chk("t1_req_after_2_edges", 32'(req), 32'd1);
    chk("t1_length", 32'(length), 32'd5);
    push(TAIL, 32'h2222_2222, 1'b1);
    chk("t1_id_hdr", 32'(flit_id), 32'(HDR));
    step();
    chk("t1_id_body", 32'(flit_id), 32'(BODY));
    step();
    chk("t1_id_tail", 32'(flit_id), 32'(TAIL));
    step();
    chk("t1_idle_req", 32'(req), 32'd0);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Stray body at the head in IDLE is dropped
    grant = 1'b0;
    push(BODY, 32'hDEAD_BEEF, 1'b0);
    chk("t2_req", 32'(req), 32'd0);
    chk("t2_valid", 32'(out_valid), 32'd0);
    step();
    chk("t2_req_after", 32'(req), 32'd0);
    chk("t2_in_ready", 32'(in_ready), 32'd1);

    // Fill the FIFO with grant low; a fifth flit must be refused
    push(HDR,  32'h0000_0007, 1'b1);
    push(BODY, 32'h3333_3333, 1'b1);
    push(BODY, 32'h4444_4444, 1'b1);
    push(TAIL, 32'h5555_5555, 1'b1);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    chk("t3_full_req", 32'(req), 32'd1);
    in_valid = 1'b1; in_flit_id = HDR; in_flit = 32'h0000_0FFF;
    step();
    chk("t3_5th_in_ready", 32'(in_ready), 32'd0);
    chk("t3_5th_req", 32'(req), 32'd1);
    step();
    in_valid = 1'b0;
    grant = 1'b1;
    wait_idle("t3");
    chk("t3_length", 32'(length), 32'd7);

    // Grant gap after the second body
    grant = 1'b0;
    push(HDR,  32'h0000_0003, 1'b1);
    push(BODY, 32'hB0B0_0001, 1'b1);
    push(BODY, 32'hB0B0_0002, 1'b1);
    push(BODY, 32'hB0B0_0003, 1'b1);
    fork
      push(TAIL, 32'hEEEE_0004, 1'b1);
      begin
        grant = 1'b1;
        step();
        chk("t4_hdr_valid", 32'(out_valid), 32'd1);
        step();
        step();
        chk("t4_b2_id", 32'(flit_id), 32'(BODY));
        step();
        grant = 1'b0;
        #1;
        chk("t4_gap1_valid", 32'(out_valid), 32'd0);
        chk("t4_gap1_req", 32'(req), 32'd1);
        step();
        chk("t4_gap2_valid", 32'(out_valid), 32'd0);
        chk("t4_gap2_req", 32'(req), 32'd1);
        step();
        grant = 1'b1;
      end
    join
    wait_idle("t4");
    chk("t4_length", 32'(length), 32'd3);

    // New header before the tail: resend from REQ with the new length
    push(HDR,  32'h0000_0009, 1'b1);
    push(BODY, 32'hC0C0_0001, 1'b1);
    push(HDR,  32'h0000_000A, 1'b1);
    push(BODY, 32'hC0C0_0002, 1'b1);
    push(TAIL, 32'hC0C0_0003, 1'b1);
    wait_idle("t5");
    chk("t5_length", 32'(length), 32'h00A);

    // Reset in the middle of SEND with three flits still buffered
    grant = 1'b0;
    push(HDR,  32'h0000_0004, 1'b1);
    push(BODY, 32'hD0D0_0001, 1'b0);
    push(BODY, 32'hD0D0_0002, 1'b0);
    push(BODY, 32'hD0D0_0003, 1'b0);
    grant = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_length", 32'(length), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_out_flit", 32'(out_flit), 32'd0);
    chk("t6_sb_after_rst", 32'(sb.size()), 32'd0);
`ifdef FLIT_REQUESTER_PKTCNT_EN
    chk("t6_pkt_count_rst", 32'(pkt_count), 32'd0);
`endif
    push(HDR,  32'h0000_0002, 1'b1);
    push(TAIL, 32'hF0F0_0001, 1'b1);
    wait_idle("t6");
    chk("t6_new_length", 32'(length), 32'd2);
`ifdef FLIT_REQUESTER_PKTCNT_EN
    chk("t6_pkt_count", 32'(pkt_count), 32'd1);
`endif
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flit_requester.md
FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the flit payload width in bits (minimum 12).
REQ-002 Parameter DEPTH, default 4, SHALL set the FIFO depth in flits; it SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream flit present.
REQ-006 in_ready  output  1  FIFO can accept a flit.
REQ-007 in_flit  input  DATA_W  upstream flit payload.
REQ-008 in_flit_id  input  3  upstream flit type: 3'b001 header, 3'b010 body, 3'b100 tail.
REQ-009 grant  input  1  this port's one-hot grant bit from the switch arbiter.
REQ-010 req  output  1  request toward the arbiter.
REQ-011 flit_id  output  3  type of the flit currently being sent, or 3'b000 when none is sent.
REQ-012 length  output  12  timeout length taken from the current packet header.
REQ-013 out_valid  output  1  out_flit is being transferred this cycle.
REQ-014 out_flit  output  DATA_W  head flit payload.

Function
REQ-015 The FIFO SHALL store {in_flit_id, in_flit}, and in_ready SHALL equal !full.
REQ-016 The FIFO SHALL push when in_valid && in_ready, and a push SHALL NOT pass the FIFO in the same cycle.
REQ-017 The FIFO SHALL pop when out_valid, or on a discard (REQ-020).
REQ-018 When full and popping in the same cycle, in_ready SHALL still be 0 in that cycle.
REQ-019 The block SHALL implement three states: IDLE, REQ and SEND.
REQ-020 IDLE: if the head is a header, the block SHALL go to REQ and load length from head payload[11:0]; if the head is body or tail, it SHALL pop and discard that flit and stay in IDLE.
REQ-021 REQ: the block SHALL drive req=1 and go to SEND on an edge where grant=1.
REQ-022 SEND: the block SHALL drive req=1, out_valid = grant && !empty, flit_id = head id when out_valid (else 3'b000), and out_flit = head payload.
REQ-023 SEND, popping a tail: the block SHALL go to IDLE, with req=0 from the next cycle.
REQ-024 SEND with grant=0 (arbiter timeout or preemption) and no tail popped: the block SHALL go to REQ, keeping length and the unsent flits.
REQ-025 SEND with the FIFO empty: the block SHALL stall with out_valid=0, req held at 1, and no state change.
REQ-026 SEND with a header at the head and no tail seen: the block SHALL NOT pop it, SHALL go to REQ, and SHALL reload length from it.
REQ-027 Latency: a header accepted at edge t into an empty FIFO in IDLE SHALL give req=1 after edge t+1, and the first out_valid no earlier than the cycle after the edge on which grant is sampled high in REQ.
REQ-028 Throughput in SEND SHALL be one flit per cycle while grant=1 and the FIFO is non-empty.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH, and the occupancy count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-030 On rst the block SHALL set the state to IDLE, empty the FIFO, and drive in_ready=1, req=0, flit_id=3'b000, length=0, out_valid=0 and out_flit=0 from the next cycle.
REQ-031 Reset mid-packet SHALL drop all buffered flits with no partial output afterward.

Configuration
REQ-032 With macro FLIT_REQUESTER_PKTCNT_EN defined, the block SHALL add output pkt_count (16 bits), reset to 0, incrementing by 1 on each tail pop and wrapping from 16'hFFFF to 0.
REQ-033 Without FLIT_REQUESTER_PKTCNT_EN, pkt_count SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-034 Push header(len=12'd5), body, tail, with grant tied 1 -> req rises after 2 edges; flit_id sequence 001, 010, 100 on consecutive cycles; length=5; IDLE afterwards with req=0.
REQ-035 Push 4 flits with DEPTH=4 and grant=0 -> in_ready=0 after the 4th push; a 5th in_valid is not accepted; req=1 stays held.
REQ-036 Header + 3 bodies + tail, grant dropped for 2 cycles after the 2nd body -> out_valid=0 and req=1 during the gap; the remaining body and tail are sent with no loss or duplication.
REQ-037 Body flit at the head in IDLE -> discarded in 1 cycle, req stays 0, out_valid stays 0.
REQ-038 rst asserted mid-SEND with 3 flits buffered -> next cycle req=0, in_ready=1, length=0; a later new packet is sent cleanly; with FLIT_REQUESTER_PKTCNT_EN, pkt_count=0 after reset and 1 after the tail.
